// File: rtl/sha3_pio_bridge.sv
// sha3_pio_bridge: HPS PIO chunk/toggle bridge to the SHA3 core; define SHA3_BRIDGE_TIMEOUT_EN for the core watchdog
module sha3_pio_bridge #(
  parameter int WORD_W      = 32,
  parameter int N_IN        = 8,
  parameter int N_OUT       = 8,
  parameter int BLOCK_WORDS = 34,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset,
  input  logic [N_IN*WORD_W-1:0]        hps_data_in,
  input  logic [WORD_W-1:0]             hps_ctrl,
  input  logic                          hps_flag,
  output logic                          hps_ack,
  output logic [N_OUT*WORD_W-1:0]       hps_data_out,
  output logic [WORD_W-1:0]             hps_status,
  output logic [BLOCK_WORDS*WORD_W-1:0] core_block,
  output logic                          core_start,
  output logic                          core_last,
  output logic                          core_init,
  input  logic                          core_done,
  input  logic [N_OUT*WORD_W-1:0]       core_digest
);
  localparam int CHUNKS = (BLOCK_WORDS + N_IN - 1) / N_IN;
  typedef enum logic [1:0] {WAIT_CHUNK, START, WAIT_CORE, ACK} state_t;
  state_t state;
  logic flag_q, flag_seen, last_q, digest_valid, timeout, pending, to_ev, unused_ctrl;
  logic [7:0] chunk_idx;
  logic [WORD_W-1:0] blk [BLOCK_WORDS];
  assign pending = flag_q != flag_seen;
  assign unused_ctrl = ^hps_ctrl[WORD_W-1:2];
  for (genvar g = 0; g < BLOCK_WORDS; g++) begin : g_blk
    assign core_block[g*WORD_W +: WORD_W] = blk[g];
  end
`ifdef SHA3_BRIDGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk_clk) begin
    cnt <= (reset_reset || state != WAIT_CORE) ? '0 : cnt + CW'(1);
  end
  assign to_ev = cnt == CW'(TIMEOUT_CYC - 2);
`else
  logic [31:0] unused_to;
  assign unused_to = 32'(TIMEOUT_CYC);
  assign to_ev = 1'b0;
`endif
  always_comb begin
    hps_status = '0;
    hps_status[0] = state != WAIT_CHUNK;
    hps_status[1] = digest_valid;
    hps_status[2] = timeout;
    hps_status[15:8] = chunk_idx;
  end
  always_ff @(posedge clk_clk) begin
    flag_q <= hps_flag;
    core_start <= 1'b0;
    core_init <= 1'b0;
    if (reset_reset) begin
      flag_seen <= hps_flag;
      state <= WAIT_CHUNK;
      chunk_idx <= '0;
      last_q <= 1'b0;
      digest_valid <= 1'b0;
      timeout <= 1'b0;
      hps_ack <= 1'b0;
      hps_data_out <= '0;
      core_last <= 1'b0;
      for (int w = 0; w < BLOCK_WORDS; w++) blk[w] <= '0;
    end else begin
      case (state)
        WAIT_CHUNK: if (pending) begin
          flag_seen <= flag_q;
          last_q <= hps_ctrl[0];
          timeout <= 1'b0;
          digest_valid <= 1'b0;
          if (hps_ctrl[1]) begin
            core_init <= 1'b1;
            chunk_idx <= '0;
            state <= ACK;
          end else begin
            for (int w = 0; w < BLOCK_WORDS; w++)
              if (chunk_idx == 8'(w / N_IN)) blk[w] <= hps_data_in[(w % N_IN)*WORD_W +: WORD_W];
            state <= (chunk_idx == 8'(CHUNKS - 1)) ? START : ACK;
            chunk_idx <= (chunk_idx == 8'(CHUNKS - 1)) ? chunk_idx : chunk_idx + 8'd1;
          end
        end
        START: begin
          core_start <= 1'b1;
          core_last <= last_q;
          chunk_idx <= '0;
          state <= WAIT_CORE;
        end
        WAIT_CORE: if (core_done) begin
          hps_data_out <= core_last ? core_digest : hps_data_out;
          digest_valid <= core_last;
          state <= ACK;
        end else if (to_ev) begin
          timeout <= 1'b1;
          state <= ACK;
        end
        default: begin
          hps_ack <= ~hps_ack;
          state <= WAIT_CHUNK;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sha3_pio_bridge.sv
// tb_sha3_pio_bridge: randomized bench for sha3_pio_bridge with a word-level block/digest reference model
module tb_sha3_pio_bridge;
  localparam int WORD_W = 32, N_IN = 8, N_OUT = 8, BLOCK_WORDS = 34;
  localparam int CHUNKS = (BLOCK_WORDS + N_IN - 1) / N_IN;
  localparam int TO_CYC = 16;
`ifdef SHA3_BRIDGE_TIMEOUT_EN
  localparam int MAX_LAT = 12;
`else
  localparam int MAX_LAT = 30;
`endif
  logic clk_clk = 0, reset_reset, hps_flag, hps_ack, core_start, core_last, core_init, core_done;
  logic [N_IN*WORD_W-1:0] hps_data_in;
  logic [WORD_W-1:0] hps_ctrl, hps_status;
  logic [N_OUT*WORD_W-1:0] hps_data_out, core_digest, next_digest, cm_digest;
  logic [BLOCK_WORDS*WORD_W-1:0] core_block, got_blk;
  logic got_last;
  int errs = 0, checks = 0, n_start = 0, n_init = 0, cm_lat = 5;
  bit core_en = 1;
  logic [WORD_W-1:0] m_blk [BLOCK_WORDS];
  logic [N_OUT*WORD_W-1:0] m_out = '0;
  int m_idx = 0;
  bit m_dv = 0, m_to = 0;

  sha3_pio_bridge #(.WORD_W(WORD_W), .N_IN(N_IN), .N_OUT(N_OUT), .BLOCK_WORDS(BLOCK_WORDS),
                    .TIMEOUT_CYC(TO_CYC)) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .hps_data_in(hps_data_in), .hps_ctrl(hps_ctrl),
    .hps_flag(hps_flag), .hps_ack(hps_ack), .hps_data_out(hps_data_out), .hps_status(hps_status),
    .core_block(core_block), .core_start(core_start), .core_last(core_last), .core_init(core_init),
    .core_done(core_done), .core_digest(core_digest));

  always #5 clk_clk = ~clk_clk;

  initial forever begin
    @(posedge clk_clk); #1;
    if (core_start === 1'b1) n_start++;
    if (core_init === 1'b1) n_init++;
  end

  initial begin
    core_done = 0;
    core_digest = '0;
    forever begin
      @(posedge clk_clk); #1;
      if (core_start === 1'b1) begin
        got_blk = core_block;
        got_last = core_last;
        if (core_en) begin
          repeat (cm_lat) @(posedge clk_clk);
          #1;
          core_digest = next_digest;
          cm_digest = next_digest;
          core_done = 1;
          @(posedge clk_clk); #1;
          core_done = 0;
        end
      end
    end
  end

  function automatic logic [N_IN*WORD_W-1:0] rand_in();
    logic [N_IN*WORD_W-1:0] r;
    for (int i = 0; i < N_IN; i++) r[i*WORD_W +: WORD_W] = $urandom;
    return r;
  endfunction

  function automatic logic [N_OUT*WORD_W-1:0] rand_out();
    logic [N_OUT*WORD_W-1:0] r;
    for (int i = 0; i < N_OUT; i++) r[i*WORD_W +: WORD_W] = $urandom;
    return r;
  endfunction

  function automatic logic [BLOCK_WORDS*WORD_W-1:0] pack_blk();
    logic [BLOCK_WORDS*WORD_W-1:0] r;
    for (int i = 0; i < BLOCK_WORDS; i++) r[i*WORD_W +: WORD_W] = m_blk[i];
    return r;
  endfunction

  function automatic logic [31:0] exp_st();
    return {16'b0, 8'(m_idx), 5'b0, m_to, m_dv, 1'b0};
  endfunction

  task automatic model_chunk(input logic [N_IN*WORD_W-1:0] d, input logic [WORD_W-1:0] c);
    m_to = 0;
    if (c[1]) begin
      m_idx = 0;
      m_dv = 0;
    end else begin
      for (int i = 0; i < N_IN; i++)
        if (m_idx*N_IN + i < BLOCK_WORDS) m_blk[m_idx*N_IN + i] = d[i*WORD_W +: WORD_W];
      m_dv = 0;
      if (m_idx == CHUNKS - 1) begin
        m_idx = 0;
        if (!core_en) m_to = 1;
        else if (c[0]) begin
          m_out = cm_digest;
          m_dv = 1;
        end
      end else m_idx++;
    end
  endtask

  task automatic send_chunk(input logic [N_IN*WORD_W-1:0] d, input logic [WORD_W-1:0] c, output int lat);
    logic a0;
    a0 = hps_ack;
    hps_data_in = d;
    hps_ctrl = c;
    hps_flag = ~hps_flag;
    lat = -1;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk_clk); #1;
      if (hps_ack !== a0) begin
        lat = i;
        break;
      end
    end
    model_chunk(d, c);
  endtask

  task automatic test_reset();
    reset_reset = 1;
    hps_flag = 1;
    hps_ctrl = '0;
    hps_data_in = '0;
    for (int i = 0; i < BLOCK_WORDS; i++) m_blk[i] = '0;
    repeat (3) @(posedge clk_clk);
    #1;
    reset_reset = 0;
    repeat (10) @(posedge clk_clk);
    #1;
    checks++; if (hps_ack !== 1'b0) begin errs++; $display("FAIL reset_ack: got %b exp 0", hps_ack); end
    checks++; if (hps_status !== 32'h0) begin errs++; $display("FAIL reset_status: got %h exp 0", hps_status); end
    checks++; if (n_start !== 0) begin errs++; $display("FAIL reset_start: got %0d exp 0", n_start); end
    checks++; if (n_init !== 0) begin errs++; $display("FAIL reset_init: got %0d exp 0", n_init); end
    checks++; if (hps_data_out !== '0) begin errs++; $display("FAIL reset_dout: got %h exp 0", hps_data_out); end
    checks++; if (core_block !== '0) begin errs++; $display("FAIL reset_block: got %h exp 0", core_block); end
    checks++; if (core_last !== 1'b0) begin errs++; $display("FAIL reset_last: got %b exp 0", core_last); end
  endtask

  task automatic test_five_chunks();
    logic [N_IN*WORD_W-1:0] d;
    int lat, s0;
    s0 = n_start;
    next_digest = 256'ha7ffc6f8bf1ed76651c14756a061d662f580ff4de43b49fa82d80a4b80f8434a;
    cm_lat = MAX_LAT < 20 ? MAX_LAT : 20;
    for (int c = 0; c < CHUNKS; c++) begin
      d = '0;
      if (c == 0) d[31:0] = 32'h6;
      if (c == CHUNKS - 1) begin
        d = rand_in();
        d[31:0] = 32'h0;
        d[63:32] = 32'h8000_0000;
      end
      send_chunk(d, 32'h1, lat);
      checks++;
      if (lat !== (c == CHUNKS - 1 ? cm_lat + 5 : 3)) begin
        errs++; $display("FAIL five_lat%0d: got %0d exp %0d", c, lat, c == CHUNKS - 1 ? cm_lat + 5 : 3);
      end
    end
    checks++; if (core_block[31:0] !== 32'h6) begin errs++; $display("FAIL five_w0: got %h exp 6", core_block[31:0]); end
    checks++; if (core_block[33*WORD_W +: WORD_W] !== 32'h8000_0000) begin errs++; $display("FAIL five_w33: got %h exp 80000000", core_block[33*WORD_W +: WORD_W]); end
    checks++; if (got_blk !== pack_blk()) begin errs++; $display("FAIL five_blk: got %h exp %h", got_blk, pack_blk()); end
    checks++; if (got_last !== 1'b1) begin errs++; $display("FAIL five_last: got %b exp 1", got_last); end
    checks++; if (hps_data_out !== 256'ha7ffc6f8bf1ed76651c14756a061d662f580ff4de43b49fa82d80a4b80f8434a) begin errs++; $display("FAIL five_digest: got %h", hps_data_out); end
    checks++; if (hps_status !== exp_st()) begin errs++; $display("FAIL five_status: got %h exp %h", hps_status, exp_st()); end
    checks++; if (n_start - s0 !== 1) begin errs++; $display("FAIL five_starts: got %0d exp 1", n_start - s0); end
  endtask

  task automatic test_multi_block(input int nb, input bit rnd);
    logic [N_IN*WORD_W-1:0] d;
    logic [WORD_W-1:0] c;
    int lat, exp_lat, s0;
    bit lastb, fin;
    s0 = n_start;
    for (int b = 0; b < nb; b++) begin
      lastb = rnd ? 1'($urandom) : (b == nb - 1);
      next_digest = rand_out();
      cm_lat = $urandom_range(1, MAX_LAT);
      do begin
        fin = (m_idx == CHUNKS - 1);
        d = rand_in();
        c = ($urandom & 32'hFFFF_FFFC) | {31'b0, fin ? lastb : 1'($urandom)};
        exp_lat = fin ? cm_lat + 5 : 3;
        send_chunk(d, c, lat);
        checks++; if (lat !== exp_lat) begin errs++; $display("FAIL blk%0d_lat: got %0d exp %0d", b, lat, exp_lat); end
      end while (!fin);
      checks++; if (got_blk !== pack_blk()) begin errs++; $display("FAIL blk%0d_data: got %h exp %h", b, got_blk, pack_blk()); end
      checks++; if (got_last !== lastb) begin errs++; $display("FAIL blk%0d_last: got %b exp %b", b, got_last, lastb); end
      checks++; if (hps_data_out !== m_out) begin errs++; $display("FAIL blk%0d_dout: got %h exp %h", b, hps_data_out, m_out); end
      checks++; if (hps_status !== exp_st()) begin errs++; $display("FAIL blk%0d_status: got %h exp %h", b, hps_status, exp_st()); end
    end
    checks++; if (n_start - s0 !== nb) begin errs++; $display("FAIL multi_starts: got %0d exp %0d", n_start - s0, nb); end
  endtask

  task automatic test_clear();
    logic [BLOCK_WORDS*WORD_W-1:0] b0;
    int lat, i0, s0;
    i0 = n_init;
    s0 = n_start;
    send_chunk(rand_in(), 32'h2, lat);
    checks++; if (hps_status !== exp_st()) begin errs++; $display("FAIL clr0_status: got %h exp %h", hps_status, exp_st()); end
    for (int k = 0; k < 2; k++) begin
      send_chunk(rand_in(), ($urandom & 32'hFFFF_FFFC) | 32'h1, lat);
      checks++; if (lat !== 3) begin errs++; $display("FAIL clr_chunk_lat: got %0d exp 3", lat); end
    end
    b0 = core_block;
    send_chunk(rand_in(), 32'h3, lat);
    checks++; if (lat !== 3) begin errs++; $display("FAIL clr_lat: got %0d exp 3", lat); end
    checks++; if (n_init - i0 !== 2) begin errs++; $display("FAIL clr_init: got %0d exp 2", n_init - i0); end
    checks++; if (core_block !== b0) begin errs++; $display("FAIL clr_block: got %h exp %h", core_block, b0); end
    checks++; if (core_block !== pack_blk()) begin errs++; $display("FAIL clr_model: got %h exp %h", core_block, pack_blk()); end
    checks++; if (hps_status !== exp_st()) begin errs++; $display("FAIL clr_status: got %h exp %h", hps_status, exp_st()); end
    checks++; if (n_start !== s0) begin errs++; $display("FAIL clr_start: got %0d exp %0d", n_start, s0); end
  endtask

  task automatic test_single_chunk();
    int lat;
    send_chunk(rand_in(), $urandom & 32'hFFFF_FFFD, lat);
    checks++; if (lat !== 3) begin errs++; $display("FAIL single_lat: got %0d exp 3", lat); end
    checks++; if (hps_status[15:8] !== 8'd1) begin errs++; $display("FAIL single_idx: got %0d exp 1", hps_status[15:8]); end
    checks++; if (hps_status !== exp_st()) begin errs++; $display("FAIL single_status: got %h exp %h", hps_status, exp_st()); end
    checks++; if (core_block !== pack_blk()) begin errs++; $display("FAIL single_block: got %h exp %h", core_block, pack_blk()); end
  endtask

  task automatic test_stray_done();
    logic [WORD_W-1:0] st;
    logic a0;
    st = hps_status;
    a0 = hps_ack;
    core_digest = rand_out();
    core_done = 1;
    @(posedge clk_clk); #1;
    core_done = 0;
    repeat (3) @(posedge clk_clk);
    #1;
    checks++; if (hps_data_out !== m_out) begin errs++; $display("FAIL stray_dout: got %h exp %h", hps_data_out, m_out); end
    checks++; if (hps_status !== st) begin errs++; $display("FAIL stray_status: got %h exp %h", hps_status, st); end
    checks++; if (hps_ack !== a0) begin errs++; $display("FAIL stray_ack: got %b exp %b", hps_ack, a0); end
  endtask

  task automatic test_early_toggle();
    logic [N_IN*WORD_W-1:0] d;
    logic a0;
    d = rand_in();
    a0 = hps_ack;
    hps_data_in = d;
    hps_ctrl = 32'h0;
    hps_flag = ~hps_flag;
    @(posedge clk_clk); #1;
    hps_flag = ~hps_flag;
    repeat (2) @(posedge clk_clk);
    #1;
    checks++; if (hps_ack !== ~a0) begin errs++; $display("FAIL early_ack1: got %b exp %b", hps_ack, ~a0); end
    repeat (2) @(posedge clk_clk);
    #1;
    checks++; if (hps_ack !== a0) begin errs++; $display("FAIL early_ack2: got %b exp %b", hps_ack, a0); end
    model_chunk(d, 32'h0);
    model_chunk(d, 32'h0);
    checks++; if (core_block !== pack_blk()) begin errs++; $display("FAIL early_block: got %h exp %h", core_block, pack_blk()); end
    checks++; if (hps_status !== exp_st()) begin errs++; $display("FAIL early_status: got %h exp %h", hps_status, exp_st()); end
  endtask

`ifdef SHA3_BRIDGE_TIMEOUT_EN
  task automatic test_timeout();
    int lat;
    bit fin;
    core_en = 0;
    do begin
      fin = (m_idx == CHUNKS - 1);
      send_chunk(rand_in(), 32'h1, lat);
      checks++; if (lat !== (fin ? 3 + TO_CYC : 3)) begin errs++; $display("FAIL to_lat: got %0d exp %0d", lat, fin ? 3 + TO_CYC : 3); end
    end while (!fin);
    checks++; if (hps_status !== exp_st()) begin errs++; $display("FAIL to_status: got %h exp %h", hps_status, exp_st()); end
    checks++; if (hps_data_out !== m_out) begin errs++; $display("FAIL to_dout: got %h exp %h", hps_data_out, m_out); end
    core_en = 1;
    send_chunk(rand_in(), 32'h0, lat);
    checks++; if (hps_status !== exp_st()) begin errs++; $display("FAIL to_clear: got %h exp %h", hps_status, exp_st()); end
  endtask
`endif

  initial begin
    test_reset();
    test_five_chunks();
    test_multi_block(2, 0);
    test_clear();
    test_single_chunk();
    test_multi_block(3, 1);
    test_stray_done();
    test_early_toggle();
`ifdef SHA3_BRIDGE_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/sha3_pio_bridge.md
Name: sha3_pio_bridge

Overview:
- Parametrised successor to the fixed 8-in/8-out PIO hookup between the HPS and the SHA3-256 core.
- Accepts message words from HPS PIO exports in chunks of N_IN words, using a toggle handshake, and assembles a full rate block of BLOCK_WORDS words.
- Launches the Keccak core per block, captures the digest after the final block, and returns it on N_OUT output words with an acknowledge toggle.
- Sits in the FPGA fabric between the hps system exports and the sha3 core.

Parameters:
WORD_W, 32, width of each PIO word
N_IN, 8, input words per chunk (sha_in exports)
N_OUT, 8, digest words (sha_out exports)
BLOCK_WORDS, 34, rate block size in words (1088 bits for SHA3-256)
TIMEOUT_CYC, 4096, core watchdog limit in cycles (used only with the optional feature)

Ports:
clk_clk  in  1  system clock
reset_reset  in  1  synchronous active-high reset
hps_data_in  in  N_IN*WORD_W  chunk words from HPS; word 0 at LSBs
hps_ctrl  in  WORD_W  bit0 = last block, bit1 = clear/re-init; other bits ignored
hps_flag  in  1  HPS toggle: new chunk valid (flag_out export)
hps_ack  out  1  bridge toggle: chunk consumed (flag_in export)
hps_data_out  out  N_OUT*WORD_W  registered digest
hps_status  out  WORD_W  bit0 busy, bit1 digest_valid, bit2 timeout, bits[15:8] chunk_idx, others 0
core_block  out  BLOCK_WORDS*WORD_W  assembled rate block
core_start  out  1  one-cycle start pulse
core_last  out  1  qualifies core_start: final block
core_init  out  1  one-cycle state-clear pulse
core_done  in  1  one-cycle completion pulse from core
core_digest  in  N_OUT*WORD_W  core digest, valid with core_done

Behaviour:
- Constant CHUNKS = ceil(BLOCK_WORDS/N_IN).
  - Chunk c writes words c*N_IN .. min(c*N_IN+N_IN, BLOCK_WORDS)-1.
  - Excess input words in the final chunk are ignored (default: chunk 4 uses words 0..1).
- Reset state:
  - All outputs, core_block, chunk_idx and the FSM clear to 0; FSM goes to WAIT_CHUNK.
  - flag_q and flag_seen load the current hps_flag, so no spurious toggle is seen after reset release.
  - Reset mid-operation abandons the block; no core_init is issued.
- Toggle detect: flag_q <= hps_flag each cycle. A new chunk is pending when flag_q != flag_seen, and is evaluated only in WAIT_CHUNK.
- WAIT_CHUNK (pending chunk):
  - Latch hps_ctrl and set flag_seen <= flag_q.
  - If ctrl bit1 = 1:
    - Pulse core_init; set chunk_idx = 0 and digest_valid = 0; go to ACK.
    - Data is not written; bit1 takes priority over bit0.
  - Otherwise:
    - Write the chunk words into core_block and clear digest_valid.
    - If chunk_idx == CHUNKS-1, go to START; else increment chunk_idx and go to ACK.
- START: core_start = 1 for one cycle; core_last = latched bit0, held until the next START. Set chunk_idx = 0; go to WAIT_CORE.
- WAIT_CORE:
  - On core_done with last = 1: register core_digest into hps_data_out and set digest_valid = 1.
  - On core_done in either case: go to ACK.
  - core_done seen in any other state is ignored.
- ACK: toggle hps_ack; go to WAIT_CHUNK.
- Latency:
  - Non-final chunk: hps_ack toggles on the 3rd rising edge after hps_flag changes.
  - Final chunk: core_start is asserted on the 3rd edge; hps_ack toggles 2 edges after core_done.
- busy = (FSM != WAIT_CHUNK).
- ctrl bit0 on a non-final chunk is ignored.
- Protocol: the HPS must not toggle hps_flag again before hps_ack toggles.
  - A single early toggle is held pending until WAIT_CHUNK.
  - A double toggle cancels itself and is lost (documented violation, no recovery).
- Multi-block messages: chunk_idx wraps to 0 after each block; the core keeps its state between blocks until core_init.

Optional Feature:
- Macro SHA3_BRIDGE_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_CORE and clears on entry.
  - If it reaches TIMEOUT_CYC without core_done, set status bit2, go to ACK, and leave hps_data_out unchanged.
  - Bit2 clears on the next accepted chunk or on reset.
- Not defined: no counter; WAIT_CORE waits indefinitely; bit2 reads 0.

Test Plan:
- Reset with hps_flag=1 held, release, idle 10 cycles -> no core_start, hps_ack=0, hps_status=0.
- Five chunks, ctrl=0x1, words 0x00000006 / 0x80000000 in the right places; core model returns digest 0xA7FFC6F8... after 20 cycles -> core_block word 0 = chunk0 word0, core_last=1, hps_data_out equals the digest, status bit1=1, five hps_ack toggles.
- Single chunk with flag toggle at edge t -> hps_ack toggles at edge t+3; chunk_idx reads 1 in status[15:8].
- Two blocks (ctrl=0x0, then ctrl=0x1) -> two core_start pulses with core_last 0 then 1; digest captured only after the second block.
- Two chunks, then ctrl=0x2 toggle -> core_init pulse, chunk_idx=0, core_block unchanged, ack toggles, digest_valid=0.
- With SHA3_BRIDGE_TIMEOUT_EN and TIMEOUT_CYC=16, core_done never asserted -> status bit2=1 and ack toggles 16 cycles after core_start; the next chunk clears bit2.
